// File: rtl/xor_arbiter.sv
// xor_arbiter: round-robin front end that shares one registered XOR unit
// (1-cycle latency) among N_REQ requesters. Each operation takes three
// cycles: grant/issue, XOR unit compute, result capture.
// Optional build macro: XOR_ARB_STATS_EN adds a 16-bit completed-operation
// counter on port ops_cnt.
module xor_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] a_bus,
   input  logic [N_REQ*WIDTH-1:0] b_bus,
   output logic [N_REQ-1:0]       gnt,
   output logic [WIDTH-1:0]       xor_a,
   output logic [WIDTH-1:0]       xor_b,
   input  logic [WIDTH-1:0]       xor_out,
   output logic [WIDTH-1:0]       res_data,
   output logic [ID_W-1:0]        res_id,
   output logic                   res_valid,
   output logic                   busy
`ifdef XOR_ARB_STATS_EN
   ,
   output logic [15:0]            ops_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;

   state_t          state;
   logic [ID_W-1:0] ptr;   // last requester served
   logic [ID_W-1:0] id;    // requester owning the in-flight operation
   logic [ID_W-1:0] win;   // current round-robin winner among raised req bits

   // First raised request found when scanning upward from ptr+1, wrapping
   // at N_REQ. Scanning from the far end keeps the nearest hit.
   function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  p);
      logic [ID_W-1:0] idx;
      logic [ID_W-1:0] best;
      best = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = ID_W'((int'(p) + k) % N_REQ);
         if (r[idx]) best = idx;
      end
      return best;
   endfunction

   assign win  = rr_pick(req, ptr);
   assign busy = (state != IDLE);

   // Arbitration FSM with registered grant, operand and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= ID_W'(N_REQ - 1);
         id        <= '0;
         gnt       <= '0;
         xor_a     <= '0;
         xor_b     <= '0;
         res_data  <= '0;
         res_id    <= '0;
         res_valid <= 1'b0;
      end else begin
         gnt       <= '0;
         res_valid <= 1'b0;
         unique case (state)
            // Stage 0: pick winner, grant it and launch its operands
            IDLE: begin
               if (|req) begin
                  gnt   <= N_REQ'(1) << win;
                  xor_a <= a_bus[win*WIDTH +: WIDTH];
                  xor_b <= b_bus[win*WIDTH +: WIDTH];
                  id    <= win;
                  state <= ISSUE;
               end
            end
            // Stage 1: XOR unit registers xor_a ^ xor_b on this edge
            ISSUE: begin
               state <= CAPT;
            end
            // Stage 2: capture result, tag it, advance round-robin pointer
            CAPT: begin
               res_data  <= xor_out;
               res_id    <= id;
               res_valid <= 1'b1;
               ptr       <= id;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef XOR_ARB_STATS_EN
   // Count completed operations, wrapping naturally at 16 bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ops_cnt <= '0;
      end else if (res_valid) begin
         ops_cnt <= ops_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_xor_arbiter.sv
// Bench for xor_arbiter: directed scenarios followed by random requester
// traffic; expected results are queued at issue and popped by a monitor.
module tb_xor_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] a_bus;
   logic [N*W-1:0] b_bus;
   logic [N-1:0]   gnt;
   logic [W-1:0]   xor_a;
   logic [W-1:0]   xor_b;
   logic [W-1:0]   xor_out;
   logic [W-1:0]   res_data;
   logic [IW-1:0]  res_id;
   logic           res_valid;
   logic           busy;
`ifdef XOR_ARB_STATS_EN
   logic [15:0]    ops_cnt;
`endif

   logic [W-1:0] ta [N];
   logic [W-1:0] tbv[N];

   always #5 clk = ~clk;

   always_comb begin
      a_bus = '0;
      b_bus = '0;
      for (int i = 0; i < N; i++) begin
         a_bus[i*W +: W] = ta[i];
         b_bus[i*W +: W] = tbv[i];
      end
   end

   // Stand-in for the shared XOR unit: registered, one-cycle latency
   always_ff @(posedge clk) xor_out <= xor_a ^ xor_b;

   xor_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
      .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
      .gnt(gnt), .xor_a(xor_a), .xor_b(xor_b), .xor_out(xor_out),
      .res_data(res_data), .res_id(res_id), .res_valid(res_valid),
      .busy(busy)
`ifdef XOR_ARB_STATS_EN
      , .ops_cnt(ops_cnt)
`endif
   );

   typedef struct {
      int           id;
      logic [W-1:0] data;
      int           due;
   } ent_t;

   ent_t         sb[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           busy_left = 0;
   int           mptr = N - 1;
   int           exp_ops = 0;
   logic [N-1:0] exp_gnt = '0;
   logic [W-1:0] exp_xa = '0;
   logic [W-1:0] exp_xb = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, want);
      end
   endtask

   // Reference behaviour: an idle arbiter accepts the round-robin winner,
   // then is occupied for two further edges; the result is due two edges
   // after the grant edge.
   task automatic model_edge();
      int           w;
      logic [IW-1:0] wi;
      exp_gnt = '0;
      if (rst) begin
         busy_left = 0;
         mptr      = N - 1;
         exp_xa    = '0;
         exp_xb    = '0;
         exp_ops   = 0;
         sb.delete();
         return;
      end
      if (busy_left > 0) begin
         busy_left--;
      end else if (req != '0) begin
         w = -1;
         for (int k = 1; k <= N; k++) begin
            if (w < 0 && req[IW'((mptr + k) % N)]) w = (mptr + k) % N;
         end
         wi      = IW'(w);
         exp_gnt = N'(1) << wi;
         exp_xa  = ta[wi];
         exp_xb  = tbv[wi];
         sb.push_back('{id: w, data: ta[wi] ^ tbv[wi], due: cyc + 2});
         mptr      = w;
         busy_left = 2;
         exp_ops++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      chk("gnt",   32'(gnt),   32'(exp_gnt));
      chk("busy",  32'(busy),  32'(busy_left > 0));
      chk("xor_a", 32'(xor_a), 32'(exp_xa));
      chk("xor_b", 32'(xor_b), 32'(exp_xb));
   endtask

   // Result monitor: every strobe must match the oldest outstanding entry
   always @(negedge clk) begin
      if (!rst) begin
         if (res_valid) begin
            if (sb.size() == 0) begin
               chk("res_unexpected", 32'(res_valid), 32'd0);
            end else begin
               ent_t e;
               e = sb.pop_front();
               chk("res_id",    32'(res_id),   32'(e.id));
               chk("res_data",  32'(res_data), 32'(e.data));
               chk("res_cycle", 32'(cyc),      32'(e.due));
            end
         end else if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("res_missing", 32'(res_valid), 32'd1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1;
      req = '0;
      for (int i = 0; i < N; i++) begin
         ta[i]  = '0;
         tbv[i] = '0;
      end
      tick();
      tick();
      rst = 1'b0;
      chk("rst_res_data",  32'(res_data),  32'd0);
      chk("rst_res_id",    32'(res_id),    32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_gnt",       32'(gnt),       32'd0);
      tick();

      // Single request
      ta[0] = 8'h0F; tbv[0] = 8'hFF; req = 4'b0001;
      tick();
      req = '0;
      repeat (4) tick();

      // All four requesting continuously
      for (int i = 0; i < N; i++) begin
         ta[i]  = W'(i);
         tbv[i] = 8'h10;
      end
      req = 4'hF;
      repeat (15) tick();
      req = '0;
      repeat (4) tick();

      // Pointer wrap: serve 3, then 0 and 3 together
      req = 4'b1000;
      tick();
      req = '0;
      repeat (3) tick();
      req = 4'b1001;
      tick();
      req[0] = 1'b0;
      repeat (3) tick();
      req[3] = 1'b0;
      repeat (4) tick();

      // Request arriving while busy
      req = 4'b0001;
      tick();
      req = '0;
      tick();
      ta[2] = 8'h5A; tbv[2] = 8'hC3; req = 4'b0100;
      repeat (3) tick();
      req = '0;
      repeat (3) tick();

      // Reset while the operation sits in ISSUE
      ta[0] = 8'hAA; tbv[0] = 8'h55; req = 4'b0001;
      tick();
      req = '0;
      #1 rst = 1'b1;
      #1;
      chk("rstmid_busy",      32'(busy),      32'd0);
      chk("rstmid_gnt",       32'(gnt),       32'd0);
      chk("rstmid_res_valid", 32'(res_valid), 32'd0);
      chk("rstmid_xor_a",     32'(xor_a),     32'd0);
      tick();
      rst = 1'b0;
      ta[1] = 8'h3C; tbv[1] = 8'h0F; req = 4'b0010;
      tick();
      req = '0;
      repeat (4) tick();

      // Random requester traffic obeying the hold-until-grant protocol
      repeat (600) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (exp_gnt[i]) begin
               if ($urandom_range(3) != 0) req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(3) == 0) begin
               ta[i]  = W'($urandom);
               tbv[i] = W'($urandom);
               req[i] = 1'b1;
            end
         end
      end
      req = '0;
      repeat (6) tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef XOR_ARB_STATS_EN
      chk("ops_cnt", 32'(ops_cnt), 32'(exp_ops & 16'hFFFF));
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
